// File: rtl/regfile_mp_if.sv
// regfile_mp_if: port bundle between decode/execute and the multi-port register file.
//
// Handshake semantics: there is no back-pressure. A read request (rd_en[k]) is
// always accepted and answered exactly one cycle later by rd_valid[k] with
// rd_data[k]. A write request (wr_enN) is accepted at the clock edge unless the
// clear engine owns the array (busy) or a clear starts on that edge. In either
// of those cases the write is dropped and wr_err pulses on the following cycle.
interface regfile_mp_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 3,
  parameter int NUM_RD    = 2
);
  logic [NUM_RD-1:0]           rd_en;
  logic [NUM_RD*ADDR_SIZE-1:0] rd_addr;
  logic [NUM_RD*WORD_SIZE-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_valid;
  logic                        wr_en0;
  logic                        wr_en1;
  logic [ADDR_SIZE-1:0]        wr_addr0;
  logic [ADDR_SIZE-1:0]        wr_addr1;
  logic [WORD_SIZE-1:0]        wr_data0;
  logic [WORD_SIZE-1:0]        wr_data1;
  logic                        clr;
  logic                        busy;
  logic                        wr_err;

  modport master (
    output rd_en, rd_addr, wr_en0, wr_en1, wr_addr0, wr_addr1,
           wr_data0, wr_data1, clr,
    input  rd_data, rd_valid, busy, wr_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en0, wr_en1, wr_addr0, wr_addr1,
           wr_data0, wr_data1, clr,
    output rd_data, rd_valid, busy, wr_err
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with NUM_RD registered read ports, two
// write ports (port 1 wins on address collision), write-first bypass into the
// read registers, and a one-register-per-cycle clear engine.
// Optional feature macro: REGFILE_ZERO_REG_EN makes register 0 read as zero and
// ignore writes.
module regfile_mp #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 3,
  parameter int REG_MAX   = 2 ** ADDR_SIZE,
  parameter int NUM_RD    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus,
  output logic         dbgState
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t               state;
  state_t               stateNext;
  logic [ADDR_SIZE-1:0] ptr;
  logic [ADDR_SIZE-1:0] ptrNext;

  logic [WORD_SIZE-1:0] genReg [REG_MAX];

  logic                 clrWe;
  logic                 wrOpen;
  logic                 we0Req;
  logic                 we1Req;
  logic                 we0;
  logic                 we1;
  logic                 dropNow;
  logic [WORD_SIZE-1:0] rdNext [NUM_RD];

  // Clear FSM state and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
    end
  end

  // Clear FSM next state: one pass over all registers, clr ignored while clearing.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          stateNext = CLEAR;
          ptrNext   = '0;
        end
      end
      CLEAR: begin
        if (ptr == ADDR_SIZE'(REG_MAX - 1)) begin
          stateNext = IDLE;
          ptrNext   = '0;
        end else begin
          ptrNext = ptr + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        ptrNext   = '0;
      end
    endcase
  end

  // Clear FSM outputs: clear write strobe and whether user writes may proceed.
  always_comb begin
    clrWe  = (state == CLEAR);
    wrOpen = (state == IDLE) && !bus.clr;
  end

  assign bus.busy = (state == CLEAR);
  assign dbgState = state;

  // Write qualification: zero-register masking, collision resolution, drop detection.
  always_comb begin
`ifdef REGFILE_ZERO_REG_EN
    we0Req = bus.wr_en0 && (bus.wr_addr0 != '0);
    we1Req = bus.wr_en1 && (bus.wr_addr1 != '0);
`else
    we0Req = bus.wr_en0;
    we1Req = bus.wr_en1;
`endif
    we1     = we1Req && wrOpen;
    we0     = we0Req && wrOpen && !(we1 && (bus.wr_addr1 == bus.wr_addr0));
    dropNow = (we0Req || we1Req) && !wrOpen;
  end

  // Storage array; clear and user writes are mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (clrWe) genReg[ptr] <= '0;
    if (we0)   genReg[bus.wr_addr0] <= bus.wr_data0;
    if (we1)   genReg[bus.wr_addr1] <= bus.wr_data1;
  end

  // Write-first read mux: clear, then write port 1, then write port 0, then array.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rdNext[k] = genReg[bus.rd_addr[k*ADDR_SIZE +: ADDR_SIZE]];
      if (clrWe && (ptr == bus.rd_addr[k*ADDR_SIZE +: ADDR_SIZE])) begin
        rdNext[k] = '0;
      end else if (we1 && (bus.wr_addr1 == bus.rd_addr[k*ADDR_SIZE +: ADDR_SIZE])) begin
        rdNext[k] = bus.wr_data1;
      end else if (we0 && (bus.wr_addr0 == bus.rd_addr[k*ADDR_SIZE +: ADDR_SIZE])) begin
        rdNext[k] = bus.wr_data0;
      end
`ifdef REGFILE_ZERO_REG_EN
      if (bus.rd_addr[k*ADDR_SIZE +: ADDR_SIZE] == '0) rdNext[k] = '0;
`endif
    end
  end

  // Read data/valid registers and the write-drop error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= '0;
      bus.wr_err   <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      bus.wr_err   <= dropNow;
      for (int k = 0; k < NUM_RD; k++) begin
        if (bus.rd_en[k]) bus.rd_data[k*WORD_SIZE +: WORD_SIZE] <= rdNext[k];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scenarios plus random traffic, checked every cycle
// against a memory-image model of the register file.
module tb_regfile_mp;
  localparam int W = 16;
  localparam int A = 3;
  localparam int N = 8;
  localparam int R = 2;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic dbgState;

  regfile_mp_if #(.WORD_SIZE(W), .ADDR_SIZE(A), .NUM_RD(R)) bus ();

  regfile_mp #(.WORD_SIZE(W), .ADDR_SIZE(A), .REG_MAX(N), .NUM_RD(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbgState (dbgState)
  );

  int checks;
  int failures;

  // model: memory image, which entries are defined, clear cycles remaining
  logic [W-1:0] mem [N];
  bit           known [N];
  int           clrLeft;
  logic [W-1:0] expRd [R];
  bit           expKnown [R];
  logic [W-1:0] exp_q [$];

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      known[i] = 1'b0;
      mem[i]   = '0;
    end
    if (ZERO) known[0] = 1'b1;
    clrLeft = 0;
    for (int k = 0; k < R; k++) begin
      expRd[k]    = '0;
      expKnown[k] = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idleInputs();
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.wr_en0   = 1'b0;
    bus.wr_en1   = 1'b0;
    bus.wr_addr0 = '0;
    bus.wr_addr1 = '0;
    bus.wr_data0 = '0;
    bus.wr_data1 = '0;
    bus.clr      = 1'b0;
  endtask

  task automatic waitClearDone(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      cnt++;
      cycle();
    end
  endtask

  // scoreboard: apply the edge's effects to the memory image, then compare outputs
  bit           mInClear;
  bit           mAcc;
  bit           mE0;
  bit           mE1;
  bit           mErr;
  int           mPtr;
  logic [R-1:0] mRdEn;
  logic [W-1:0] mExp;
  always @(posedge clk) begin
    if (rst_n) begin
      mInClear = (clrLeft > 0);
      mPtr     = N - clrLeft;
      mAcc     = !mInClear && !bus.clr;
      mE0      = bus.wr_en0 && !(ZERO && bus.wr_addr0 == 0);
      mE1      = bus.wr_en1 && !(ZERO && bus.wr_addr1 == 0);
      mErr     = (mE0 || mE1) && !mAcc;
      if (mInClear) begin
        mem[mPtr]   = '0;
        known[mPtr] = 1'b1;
      end
      if (mAcc && mE0) begin
        mem[bus.wr_addr0]   = bus.wr_data0;
        known[bus.wr_addr0] = 1'b1;
      end
      if (mAcc && mE1) begin
        mem[bus.wr_addr1]   = bus.wr_data1;
        known[bus.wr_addr1] = 1'b1;
      end
      if (ZERO) begin
        mem[0]   = '0;
        known[0] = 1'b1;
      end
      mRdEn = bus.rd_en;
      for (int k = 0; k < R; k++) begin
        if (mRdEn[k]) begin
          expRd[k]    = mem[bus.rd_addr[k*A +: A]];
          expKnown[k] = known[bus.rd_addr[k*A +: A]];
        end
        if (expKnown[k]) exp_q.push_back(expRd[k]);
      end
      if (mInClear) clrLeft--;
      else if (bus.clr) clrLeft = N;
      #1;
      chk("busy", {31'd0, bus.busy}, {31'd0, clrLeft > 0});
      chk("dbg_state", {31'd0, dbgState}, {31'd0, clrLeft > 0});
      chk("wr_err", {31'd0, bus.wr_err}, {31'd0, mErr});
      chk("rd_valid", {30'd0, bus.rd_valid}, {30'd0, mRdEn});
      for (int k = 0; k < R; k++) begin
        if (expKnown[k]) begin
          mExp = exp_q.pop_front();
          chk($sformatf("rd_data%0d", k), {16'd0, bus.rd_data[k*W +: W]}, {16'd0, mExp});
        end
      end
    end
  end

  int cnt;
  initial begin
    checks   = 0;
    failures = 0;
    idleInputs();
    modelReset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_wr_err", {31'd0, bus.wr_err}, 32'd0);
    chk("reset_rd_valid", {30'd0, bus.rd_valid}, 32'd0);
    chk("reset_rd_data", bus.rd_data, 32'd0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // clear from power-up: busy for exactly N cycles
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    waitClearDone(cnt);
    chk("clear_len", cnt, N);
    for (int a = 0; a < N; a += 2) begin
      bus.rd_en   = 2'b11;
      bus.rd_addr = {A'(a + 1), A'(a)};
      cycle();
      chk("clr_rd_valid", {30'd0, bus.rd_valid}, 32'd3);
      chk("clr_rd_data", bus.rd_data, 32'd0);
    end
    bus.rd_en = '0;
    cycle();
    chk("rd_valid_drop", {30'd0, bus.rd_valid}, 32'd0);

    // same-cycle bypass then array read
    bus.wr_en0 = 1'b1; bus.wr_addr0 = 3'd3; bus.wr_data0 = 16'hBEEF;
    bus.rd_en = 2'b01; bus.rd_addr = {3'd0, 3'd3};
    cycle();
    chk("bypass", {16'd0, bus.rd_data[W-1:0]}, 32'h0000BEEF);
    bus.wr_en0 = 1'b0;
    cycle();
    chk("after_bypass", {16'd0, bus.rd_data[W-1:0]}, 32'h0000BEEF);

    // collision: port 1 wins, no error
    bus.rd_en = '0;
    bus.wr_en0 = 1'b1; bus.wr_addr0 = 3'd5; bus.wr_data0 = 16'h1111;
    bus.wr_en1 = 1'b1; bus.wr_addr1 = 3'd5; bus.wr_data1 = 16'h2222;
    cycle();
    chk("collision_err", {31'd0, bus.wr_err}, 32'd0);
    idleInputs();
    bus.rd_en = 2'b10; bus.rd_addr = {3'd5, 3'd0};
    cycle();
    chk("collision_rd", {16'd0, bus.rd_data[2*W-1:W]}, 32'h00002222);

    // write during clear
    idleInputs();
    bus.wr_en0 = 1'b1; bus.wr_addr0 = 3'd2; bus.wr_data0 = 16'hAAAA;
    cycle();
    idleInputs();
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    cycle();
    bus.wr_en0 = 1'b1; bus.wr_addr0 = 3'd6; bus.wr_data0 = 16'h7777;
    cycle();
    chk("busy_wr_err", {31'd0, bus.wr_err}, 32'd1);
    bus.wr_en0 = 1'b0;
    cycle();
    chk("busy_wr_err_pulse", {31'd0, bus.wr_err}, 32'd0);
    waitClearDone(cnt);
    bus.rd_en = 2'b11; bus.rd_addr = {3'd6, 3'd2};
    cycle();
    chk("cleared_2_6", bus.rd_data, 32'd0);

    // mid-clear reset
    idleInputs();
    bus.wr_en0 = 1'b1; bus.wr_addr0 = 3'd7; bus.wr_data0 = 16'h1234;
    cycle();
    idleInputs();
    bus.rd_en = 2'b11; bus.rd_addr = {3'd7, 3'd7};
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    cycle();
    cycle();
    cycle();
    chk("pre_reset_rd", bus.rd_data, 32'h12341234);
    bus.rd_en = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_reset_rd_data", bus.rd_data, 32'd0);
    chk("mid_reset_rd_valid", {30'd0, bus.rd_valid}, 32'd0);
    modelReset();
    cycle();
    rst_n = 1'b1;
    cycle();
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    waitClearDone(cnt);
    chk("restart_clear_len", cnt, N);

    // register 0 write with same-cycle read
    bus.wr_en0 = 1'b1; bus.wr_addr0 = 3'd0; bus.wr_data0 = 16'h5555;
    bus.rd_en = 2'b01; bus.rd_addr = '0;
    cycle();
    chk("reg0_rd", {16'd0, bus.rd_data[W-1:0]}, ZERO ? 32'd0 : 32'h00005555);
    chk("reg0_err", {31'd0, bus.wr_err}, 32'd0);
    idleInputs();
    cycle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.rd_en    = R'($urandom_range(0, 3));
      bus.rd_addr  = (R*A)'($urandom);
      bus.wr_en0   = ($urandom_range(0, 1) == 1);
      bus.wr_en1   = ($urandom_range(0, 2) == 0);
      bus.wr_addr0 = A'($urandom_range(0, N - 1));
      bus.wr_addr1 = A'($urandom_range(0, N - 1));
      bus.wr_data0 = W'($urandom);
      bus.wr_data1 = W'($urandom);
      bus.clr      = ($urandom_range(0, 39) == 0);
      cycle();
    end
    idleInputs();
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
